// File: rtl/instr_seq_pkg.sv
// Shared constants, state encoding and control-word layout for instr_sequencer.
// Instruction format: {op[15:12], rd[11:8], ext/immhi[7:4], rs/immlo[3:0]}.
package instr_seq_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_CMPUI = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;

    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_AND   = 8'h01;
    localparam logic [7:0] ALU_CMPU  = 8'h08;
    localparam logic [7:0] ALU_CMP   = 8'h0B;
    localparam logic [7:0] ALU_CMPUI = 8'h0C;
    localparam logic [7:0] ALU_ANDI  = 8'h10;
    localparam logic [7:0] ALU_ORI   = 8'h20;
    localparam logic [7:0] ALU_ARSHI = 8'h83;
    localparam logic [7:0] ALU_CMPI  = 8'hB0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_MOVI2 = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  op_code;
        logic [15:0] reg_enable;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        use_imm;
        logic [15:0] imm;
    } ctrl_t;

    // Compares and NOP only set flags, so they never write a register.
    function automatic logic writes_back(input logic [7:0] opc);
        return !(opc == ALU_NOP || opc == ALU_CMP || opc == ALU_CMPU ||
                 opc == ALU_CMPI || opc == ALU_CMPUI);
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry synchronous FIFO with push/pop/flush; flush has priority over push.
module instr_fifo2 #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == 2'(DEPTH));
    assign empty = (cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Decodes queued 16-bit instruction words into registered datapath controls.
// Optional MOVI expansion is enabled with `define INSTR_SEQ_MOVI_EN.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [7:0]         opCode,
    output logic [15:0]        regEnable,
    output logic [3:0]         a_select,
    output logic [3:0]         b_select,
    output logic               use_imm,
    output logic [15:0]        immediate,
    output logic               issue_valid,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_count,
    output logic [1:0]         dbg_state
);
    // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready depends only on queue occupancy and halted, never on instr_valid.

    state_t state, state_nxt;

    logic [INSTR_W-1:0] fifo_dout;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop, fifo_flush;
    logic               accept, can_issue, head_valid, take, bypass;
    logic [INSTR_W-1:0] head;
    logic [3:0]         op, rd, ext, rs;
    logic [7:0]         imm8;

    ctrl_t dec, ctrl_nxt;
    logic  dec_legal, dec_movi;
    logic  issue_nxt, illegal_nxt;
    logic [3:0] movi_rd;
    logic [7:0] movi_imm;

    assign instr_ready = !fifo_full && !halted;
    assign accept      = instr_valid && instr_ready;
    assign can_issue   = (state == ST_IDLE) || (state == ST_ISSUE);
    assign head_valid  = !fifo_empty || accept;
    // An empty queue forwards the incoming word straight into decode for N+1 latency.
    assign head        = fifo_empty ? instr : fifo_dout;
    assign take        = can_issue && head_valid;
    assign bypass      = take && fifo_empty;
    assign fifo_pop    = take && !fifo_empty;
    assign fifo_push   = accept && !bypass;
    assign fifo_flush  = take && !dec_legal;
    assign dbg_state   = state;

    assign op   = head[15:12];
    assign rd   = head[11:8];
    assign ext  = head[7:4];
    assign rs   = head[3:0];
    assign imm8 = head[7:0];

    instr_fifo2 #(.W(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (instr),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        dec        = '0;
        dec_legal  = 1'b1;
        dec_movi   = 1'b0;
        dec.a_sel  = rd;
        dec.b_sel  = rs;
        case (op)
            OP_REG: begin
                dec.op_code = {4'h0, ext};
                dec_legal   = (ext <= 4'h9) || (ext == 4'hB) || (ext == 4'hF);
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h6, OP_CMPUI: begin
                dec.op_code = (op == OP_CMPUI) ? ALU_CMPUI : {op, 4'h0};
                dec.use_imm = 1'b1;
                dec.imm     = {8'h00, imm8};
            end
            4'h5, 4'h7, 4'h9, 4'hB: begin
                dec.op_code = {op, 4'h0};
                dec.use_imm = 1'b1;
                dec.imm     = {{8{imm8[7]}}, imm8};
            end
            OP_SHIFT: begin
                dec.op_code = {op, ext};
                if (ext[3:2] == 2'b00) begin
                    dec.use_imm = 1'b1;
                    dec.imm     = {12'h000, rs};
                end else if (ext[3:2] != 2'b01) begin
                    dec_legal = 1'b0;
                end
            end
`ifdef INSTR_SEQ_MOVI_EN
            OP_MOVI: begin
                // First half clears rd; the MOVI2 cycle ORs in the immediate.
                dec_movi    = 1'b1;
                dec.op_code = ALU_ANDI;
                dec.use_imm = 1'b1;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
        dec.reg_enable = writes_back(dec.op_code) ? (16'b1 << rd) : 16'h0000;
    end

    always_comb begin
        ctrl_nxt    = '0;
        issue_nxt   = 1'b0;
        illegal_nxt = 1'b0;
        state_nxt   = state;
        case (state)
            ST_IDLE, ST_ISSUE: begin
                if (!take) begin
                    state_nxt = ST_IDLE;
                end else if (!dec_legal) begin
                    illegal_nxt = 1'b1;
                    state_nxt   = ST_HALT;
                end else begin
                    if (dec.op_code != ALU_NOP) begin
                        ctrl_nxt  = dec;
                        issue_nxt = 1'b1;
                    end
                    state_nxt = dec_movi ? ST_MOVI2 : ST_ISSUE;
                end
            end
            ST_MOVI2: begin
                ctrl_nxt.op_code    = ALU_ORI;
                ctrl_nxt.reg_enable = 16'b1 << movi_rd;
                ctrl_nxt.a_sel      = movi_rd;
                ctrl_nxt.b_sel      = movi_imm[3:0];
                ctrl_nxt.use_imm    = 1'b1;
                ctrl_nxt.imm        = {8'h00, movi_imm};
                issue_nxt           = 1'b1;
                state_nxt           = head_valid ? ST_ISSUE : ST_IDLE;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            opCode        <= ALU_NOP;
            regEnable     <= '0;
            a_select      <= '0;
            b_select      <= '0;
            use_imm       <= 1'b0;
            immediate     <= '0;
            issue_valid   <= 1'b0;
            illegal       <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
            movi_rd       <= '0;
            movi_imm      <= '0;
        end else begin
            state       <= state_nxt;
            opCode      <= ctrl_nxt.op_code;
            regEnable   <= ctrl_nxt.reg_enable;
            a_select    <= ctrl_nxt.a_sel;
            b_select    <= ctrl_nxt.b_sel;
            use_imm     <= ctrl_nxt.use_imm;
            immediate   <= ctrl_nxt.imm;
            issue_valid <= issue_nxt;
            illegal     <= illegal_nxt;
            if (illegal_nxt) begin
                halted <= 1'b1;
            end
            if (issue_nxt) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (take && dec_movi) begin
                movi_rd  <= rd;
                movi_imm <= imm8;
            end
        end
    end

endmodule
